// File: rtl/sha3_pkg.sv
// Shared widths, state encoding and the leading-zero mask helper for the
// nonce feeder that drives sha256_3_pipeline.
package sha3_pkg;

    localparam int NONCE_W         = 32;
    localparam int TAIL_W          = 96;
    localparam int DIGEST_W        = 256;
    localparam int BLOCK_W         = 128;
    localparam int PIPE_DEPTH_DEF  = 68;
    localparam int DRAIN_SLACK_DEF = 8;
    localparam int CNT_W           = NONCE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FLUSH
    } feeder_state_t;

    // Ones in the top zero_bits positions; zero_bits = 0 yields an empty mask.
    function automatic logic [DIGEST_W-1:0] lead_mask(input logic [7:0] zero_bits);
        return ~({DIGEST_W{1'b1}} >> zero_bits);
    endfunction

endpackage

// File: rtl/sha3_hit_check.sv
// Difficulty filter: one register stage that forwards a result onto the
// hit outputs when its leading zero_bits digest bits are all clear.
module sha3_hit_check
    import sha3_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [DIGEST_W-1:0] digest_i,
    input  logic [7:0]          zero_bits_i,
    input  logic [NONCE_W-1:0]  nonce_i,
    output logic                hit_valid_o,
    output logic [NONCE_W-1:0]  hit_nonce_o,
    output logic [DIGEST_W-1:0] hit_digest_o
);

    logic                is_hit;
    logic                hit_valid_q;
    logic [NONCE_W-1:0]  hit_nonce_q;
    logic [DIGEST_W-1:0] hit_digest_q;

    assign is_hit = valid_i && ((digest_i & lead_mask(zero_bits_i)) == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_valid_q  <= 1'b0;
            hit_nonce_q  <= '0;
            hit_digest_q <= '0;
        end else begin
            hit_valid_q <= is_hit;
            if (is_hit) begin
                hit_nonce_q  <= nonce_i;
                hit_digest_q <= digest_i;
            end
        end
    end

    assign hit_valid_o  = hit_valid_q;
    assign hit_nonce_o  = hit_nonce_q;
    assign hit_digest_o = hit_digest_q;

endmodule

// File: rtl/sha3_nonce_feeder.sv
// Issues one nonce per clock into sha256_3_pipeline for a latched job and
// matches returning digests back to nonces in issue order.
module sha3_nonce_feeder
    import sha3_pkg::*;
#(
    parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
    parameter int DRAIN_SLACK = DRAIN_SLACK_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [DIGEST_W-1:0] job_initial,
    input  logic [DIGEST_W-1:0] job_midstate,
    input  logic [TAIL_W-1:0]   job_tail,
    input  logic [NONCE_W-1:0]  job_nonce_start,
    input  logic [NONCE_W-1:0]  job_nonce_end,
    input  logic [7:0]          job_zero_bits,
    input  logic                abort,
    output logic                pipe_write_en,
    output logic [DIGEST_W-1:0] pipe_digest_initial,
    output logic [DIGEST_W-1:0] pipe_digest_in,
    output logic [BLOCK_W-1:0]  pipe_block_in,
    input  logic [DIGEST_W-1:0] pipe_digest_out,
    input  logic                pipe_valid_out,
    output logic                hit_valid,
    output logic [NONCE_W-1:0]  hit_nonce,
    output logic [DIGEST_W-1:0] hit_digest,
    output logic                done,
    output logic                done_err,
    output logic                busy
);

    localparam int              LIMIT    = PIPE_DEPTH + DRAIN_SLACK;
    localparam int              TMR_W    = $clog2(LIMIT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LIMIT - 1);

    feeder_state_t       state_q;
    logic [DIGEST_W-1:0] initial_q;
    logic [DIGEST_W-1:0] midstate_q;
    logic [TAIL_W-1:0]   tail_q;
    logic [7:0]          zero_bits_q;
    logic [NONCE_W-1:0]  issue_nonce_q;
    logic [NONCE_W-1:0]  result_nonce_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [CNT_W-1:0]    outstanding_q;
    logic [TMR_W-1:0]    timer_q;
    logic                fin_q;
    logic                err_q;
    logic                done_q;
    logic                done_err_q;

    logic active, wr, res_any, res_ok, proto_err;

    // abort is combinational into the write strobe so it drops the same cycle.
    assign active    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign wr        = (state_q == ST_ISSUE) && !abort;
    assign res_any   = active && !abort && pipe_valid_out;
    assign res_ok    = res_any && (outstanding_q != '0);
    assign proto_err = res_any && (outstanding_q == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            initial_q      <= '0;
            midstate_q     <= '0;
            tail_q         <= '0;
            zero_bits_q    <= '0;
            issue_nonce_q  <= '0;
            result_nonce_q <= '0;
            remaining_q    <= '0;
            outstanding_q  <= '0;
            timer_q        <= '0;
            fin_q          <= 1'b0;
            err_q          <= 1'b0;
            done_q         <= 1'b0;
            done_err_q     <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
            outstanding_q <= outstanding_q + CNT_W'(wr) - CNT_W'(res_ok);
            if (res_ok)    result_nonce_q <= result_nonce_q + NONCE_W'(1);
            if (proto_err) err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (job_valid) begin
                        initial_q      <= job_initial;
                        midstate_q     <= job_midstate;
                        tail_q         <= job_tail;
                        zero_bits_q    <= job_zero_bits;
                        issue_nonce_q  <= job_nonce_start;
                        result_nonce_q <= job_nonce_start;
                        // end = start - 1 gives the full 2^32 range via the 33rd bit
                        remaining_q    <= {1'b0, job_nonce_end - job_nonce_start} + CNT_W'(1);
                        outstanding_q  <= '0;
                        timer_q        <= '0;
                        fin_q          <= 1'b0;
                        err_q          <= 1'b0;
                        state_q        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        timer_q <= '0;
                        state_q <= ST_FLUSH;
                    end else begin
                        issue_nonce_q <= issue_nonce_q + NONCE_W'(1);
                        remaining_q   <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            timer_q <= '0;
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        fin_q   <= 1'b0;
                        timer_q <= '0;
                        state_q <= ST_FLUSH;
                    end else if (fin_q) begin
                        // one cycle after the final result's hit slot
                        fin_q      <= 1'b0;
                        done_q     <= 1'b1;
                        done_err_q <= err_q | proto_err;
                        state_q    <= ST_IDLE;
                    end else if (res_ok && outstanding_q == CNT_W'(1)) begin
                        fin_q <= 1'b1;
                    end else if (res_any) begin
                        timer_q <= '0;
                    end else if (timer_q == TMR_LAST) begin
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= ST_FLUSH;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (timer_q == TMR_LAST) begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sha3_hit_check u_hit (
        .clk_i        (CLK),
        .rst_i        (RST),
        .valid_i      (res_ok),
        .digest_i     (pipe_digest_out),
        .zero_bits_i  (zero_bits_q),
        .nonce_i      (result_nonce_q),
        .hit_valid_o  (hit_valid),
        .hit_nonce_o  (hit_nonce),
        .hit_digest_o (hit_digest)
    );

    assign job_ready           = (state_q == ST_IDLE);
    assign busy                = (state_q != ST_IDLE);
    assign pipe_write_en       = wr;
    assign pipe_block_in       = {tail_q, issue_nonce_q};
    assign pipe_digest_initial = initial_q;
    assign pipe_digest_in      = midstate_q;
    assign done                = done_q;
    assign done_err            = done_err_q;

endmodule

// File: tb/tb_sha3_nonce_feeder.sv
// Directed bench for sha3_nonce_feeder with a fixed-latency stub pipeline
// that returns canned digests for the reference nonces.
module tb_sha3_nonce_feeder;
    import sha3_pkg::*;

    localparam int PD = 68;

    localparam logic [255:0] INIT = 256'hF59007B5_0a0b0c0d_10203040_50607080_90a0b0c0_d0e0f001_02030405_3BC75771;
    localparam logic [255:0] MID  = 256'hF7A528B9_11223344_55667788_99aabbcc_ddeeff00_12345678_3BC7FA09_E776_0000;
    localparam logic [95:0]  TAIL = 96'h252db801130dae516461011a;
    localparam logic [255:0] D0   = 256'hDB9E1922_11111111_22222222_33333333_44444444_55555555_66666666_75377467;
    localparam logic [255:0] D1   = 256'hB677077F_77777777_88888888_99999999_aaaaaaaa_bbbbbbbb_cccccccc_6C936D6C;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [255:0] job_initial = '0, job_midstate = '0;
    logic [95:0]  job_tail = '0;
    logic [31:0]  job_nonce_start = '0, job_nonce_end = '0;
    logic [7:0]   job_zero_bits = '0;
    logic         abort = 1'b0;
    logic         pipe_write_en;
    logic [255:0] pipe_digest_initial, pipe_digest_in, pipe_digest_out;
    logic [127:0] pipe_block_in;
    logic         pipe_valid_out;
    logic         hit_valid;
    logic [31:0]  hit_nonce;
    logic [255:0] hit_digest;
    logic         done, done_err, busy;

    always #5 CLK = ~CLK;

    sha3_nonce_feeder #(.PIPE_DEPTH(PD), .DRAIN_SLACK(8)) dut (
        .CLK(CLK), .RST(RST),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_initial(job_initial), .job_midstate(job_midstate), .job_tail(job_tail),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .job_zero_bits(job_zero_bits), .abort(abort),
        .pipe_write_en(pipe_write_en), .pipe_digest_initial(pipe_digest_initial),
        .pipe_digest_in(pipe_digest_in), .pipe_block_in(pipe_block_in),
        .pipe_digest_out(pipe_digest_out), .pipe_valid_out(pipe_valid_out),
        .hit_valid(hit_valid), .hit_nonce(hit_nonce), .hit_digest(hit_digest),
        .done(done), .done_err(done_err), .busy(busy)
    );

    // Canned digests: odd nonces have bit 224 set, so 31 zero bits pass but 32 fail.
    function automatic logic [255:0] dig_of(input logic [31:0] n);
        if (n == 32'h3aeb9bb8) return D0;
        if (n == 32'h3aeb9bb9) return D1;
        return {31'h0, n[0], 192'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a, n};
    endfunction

    // Stub pipeline: fixed PD-cycle delay, optional drop of one nonce.
    logic [PD-1:0] sv = '0;
    logic [31:0]   sn [PD];
    logic          drop_en = 1'b0;
    logic [31:0]   drop_nonce = '0;

    always @(posedge CLK) begin
        sv    <= {sv[PD-2:0], (pipe_write_en === 1'b1)};
        sn[0] <= pipe_block_in[31:0];
        for (int i = 1; i < PD; i++) sn[i] <= sn[i-1];
    end

    assign pipe_valid_out  = sv[PD-1] && !(drop_en && sn[PD-1] == drop_nonce);
    assign pipe_digest_out = dig_of(sn[PD-1]);

    // Monitor samples late in the low phase, well away from the rising edge.
    int          cyc = 0;
    int          acc_cyc = 0, dcyc = 0, dcnt = 0, vcnt = 0;
    logic        derr = 1'b0, drdy = 1'b0;
    logic [31:0] wq [$];
    logic [31:0] hq [$];
    logic [255:0] hdq [$];

    always @(posedge CLK) cyc <= cyc + 1;

    always begin
        @(negedge CLK);
        #3;
        if (job_valid && job_ready === 1'b1) acc_cyc = cyc + 1;
        if (pipe_write_en === 1'b1) wq.push_back(pipe_block_in[31:0]);
        if (pipe_valid_out === 1'b1) vcnt++;
        if (hit_valid === 1'b1) begin
            hq.push_back(hit_nonce);
            hdq.push_back(hit_digest);
        end
        if (done === 1'b1) begin
            dcnt++;
            derr = done_err;
            drdy = job_ready;
            dcyc = cyc;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wq.delete();
        hq.delete();
        hdq.delete();
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [7:0] zb);
        @(negedge CLK);
        job_initial     = INIT;
        job_midstate    = MID;
        job_tail        = TAIL;
        job_nonce_start = s;
        job_nonce_end   = e;
        job_zero_bits   = zb;
        job_valid       = 1'b1;
        @(negedge CLK);
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0 = dcnt;
        int n  = 0;
        while (dcnt == d0 && n < bound) begin
            @(negedge CLK);
            #4;
            n++;
        end
        chk(tag, 256'(dcnt - d0), 256'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (job_ready !== 1'b1 && n < bound) begin
            @(negedge CLK);
            #4;
            n++;
        end
        chk(tag, job_ready, 1'b1);
    endtask

    initial begin
        int h0, d0, v0;

        // reset state
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr", pipe_write_en, 1'b0);
        chk("rst_hit", hit_valid, 1'b0);
        chk("rst_done", {done, done_err}, 2'b00);
        chk("rst_blk", pipe_block_in, 128'h0);
        RST = 1'b0;

        // two-nonce reference job, every result a hit
        clear_logs();
        start_job(32'h3aeb9bb8, 32'h3aeb9bb9, 8'd0);
        #1;
        chk("t1_wr", pipe_write_en, 1'b1);
        chk("t1_blk", pipe_block_in, {TAIL, 32'h3aeb9bb8});
        chk("t1_din", pipe_digest_in, MID);
        chk("t1_dinit", pipe_digest_initial, INIT);
        wait_done("t1_done", 300);
        chk("t1_nwr", 256'(wq.size()), 256'd2);
        chk("t1_nhit", 256'(hq.size()), 256'd2);
        if (hq.size() == 2) begin
            chk("t1_n0", hq[0], 32'h3aeb9bb8);
            chk("t1_d0", hdq[0], D0);
            chk("t1_n1", hq[1], 32'h3aeb9bb9);
            chk("t1_d1", hdq[1], D1);
        end
        chk("t1_err", derr, 1'b0);
        chk("t1_rdy", drdy, 1'b1);
        chk("t1_lat", 256'(dcyc - acc_cyc), 256'd71);

        // difficulty 1: both digests have MSB set, no hits
        clear_logs();
        start_job(32'h3aeb9bb8, 32'h3aeb9bb9, 8'd1);
        wait_done("t2_done", 300);
        chk("t2_nhit", 256'(hq.size()), 256'd0);
        chk("t2_err", derr, 1'b0);

        // wrapping range, 31 leading zeros always met by stub digests
        clear_logs();
        start_job(32'hFFFFFFFE, 32'h00000001, 8'd31);
        wait_done("t3_done", 300);
        chk("t3_nwr", 256'(wq.size()), 256'd4);
        if (wq.size() == 4) begin
            chk("t3_w0", wq[0], 32'hFFFFFFFE);
            chk("t3_w1", wq[1], 32'hFFFFFFFF);
            chk("t3_w2", wq[2], 32'h00000000);
            chk("t3_w3", wq[3], 32'h00000001);
        end
        chk("t3_nhit", 256'(hq.size()), 256'd4);
        if (hq.size() == 4) begin
            chk("t3_h0", hq[0], 32'hFFFFFFFE);
            chk("t3_h2", hq[2], 32'h00000000);
            chk("t3_h3", hq[3], 32'h00000001);
        end
        chk("t3_err", derr, 1'b0);
        chk("t3_lat", 256'(dcyc - acc_cyc), 256'd73);

        // 32 zero bits: odd nonces fail, even pass
        clear_logs();
        start_job(32'd10, 32'd13, 8'd32);
        wait_done("t4_done", 300);
        chk("t4_nhit", 256'(hq.size()), 256'd2);
        if (hq.size() == 2) begin
            chk("t4_h0", hq[0], 32'd10);
            chk("t4_h1", hq[1], 32'd12);
            chk("t4_d1", hdq[1], {31'h0, 1'b0, 192'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a, 32'd12});
        end

        // abort on the third write cycle of a 10-nonce job
        clear_logs();
        d0 = dcnt;
        start_job(32'd100, 32'd109, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        abort = 1'b1;
        #1;
        chk("t5_wr_drop", pipe_write_en, 1'b0);
        @(negedge CLK);
        abort = 1'b0;
        #1;
        chk("t5_flush_busy", busy, 1'b1);
        v0 = vcnt;
        wait_idle("t5_idle", 200);
        chk("t5_nwr", 256'(wq.size()), 256'd2);
        chk("t5_stale", 256'(vcnt - v0), 256'd2);
        chk("t5_nhit", 256'(hq.size()), 256'd0);
        chk("t5_nodone", 256'(dcnt - d0), 256'd0);
        start_job(32'd7, 32'd7, 8'd0);
        wait_done("t5_new_done", 300);
        chk("t5_new_nhit", 256'(hq.size()), 256'd1);
        if (hq.size() == 1) chk("t5_new_h", hq[0], 32'd7);
        chk("t5_new_err", derr, 1'b0);

        // drain timeout: last result never returns
        clear_logs();
        drop_en    = 1'b1;
        drop_nonce = 32'd22;
        start_job(32'd20, 32'd22, 8'd0);
        wait_done("t6_done", 400);
        chk("t6_err", derr, 1'b1);
        chk("t6_lat", 256'(dcyc - acc_cyc), 256'd146);
        chk("t6_nhit", 256'(hq.size()), 256'd2);
        wait_idle("t6_idle", 200);
        drop_en = 1'b0;

        // reset mid-DRAIN
        clear_logs();
        start_job(32'd30, 32'd31, 8'd0);
        repeat (10) @(negedge CLK);
        #1;
        chk("t7_busy", busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t7_ready", job_ready, 1'b1);
        chk("t7_busy0", busy, 1'b0);
        chk("t7_wr", pipe_write_en, 1'b0);
        chk("t7_outs", {hit_valid, done, done_err}, 3'b000);
        chk("t7_blk", pipe_block_in, 128'h0);
        chk("t7_din", pipe_digest_in, 256'h0);
        h0 = hq.size();
        d0 = dcnt;
        repeat (80) @(negedge CLK);
        #4;
        chk("t7_nohit", 256'(hq.size() - h0), 256'd0);
        chk("t7_nodone", 256'(dcnt - d0), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
